// File: rtl/hex_text_sched.sv
`default_nettype none
// ============================================================================
// Module   : hex_text_sched
// Purpose  : 8x16 hex-digit text overlay with a round-robin write scheduler
//            and a single-cycle-latency pixel read path.
// Revision : 1.0
// ============================================================================
module hex_text_sched #(
    parameter int NREQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [16*NREQ-1:0]     req_val,
    input  logic [3*NREQ-1:0]      req_row,
    input  logic [4*NREQ-1:0]      req_col,
    output logic [NREQ-1:0]        ack,
    input  logic                   clr,
    output logic                   busy,
    input  logic                   blank,
    input  logic [6:0]             char_x,
    input  logic [6:0]             char_y,
    input  logic [15:0]            char_data,
    output logic                   pix
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_CLR  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] win_q, win_d;
    logic [15:0]   val_q, val_d;
    logic [2:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic          clr_pend_q, clr_pend_d;
    logic          pix_q, pix_d;

    // Each cell: {valid, digit}; deliberately not reset.
    logic [4:0]    text_mem_q [128];

    logic          w_gnt_found;
    logic [IW-1:0] w_gnt_idx;
    logic [IW-1:0] w_cand;
    logic          w_we;
    logic [6:0]    w_waddr;
    logic [4:0]    w_wdata;
    logic [3:0]    w_nib;
    logic [4:0]    w_rd_cell;
    logic          w_in_range;

    // Round-robin search begins one past the last grant.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IW'((int'(rr_q) + i) % NREQ);
            if (!w_gnt_found && req[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    always_comb begin
        case (k_q)
            2'd0:    w_nib = val_q[15:12];
            2'd1:    w_nib = val_q[11:8];
            2'd2:    w_nib = val_q[7:4];
            default: w_nib = val_q[3:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        win_d      = win_q;
        val_d      = val_q;
        row_d      = row_q;
        col_d      = col_q;
        clr_pend_d = clr_pend_q;
        w_we       = 1'b0;
        w_waddr    = '0;
        w_wdata    = '0;
        case (state_q)
            S_IDLE: begin
                if (clr || clr_pend_q) begin
                    state_d    = S_CLR;
                    cnt_d      = '0;
                    clr_pend_d = 1'b0;
                end else if (w_gnt_found) begin
                    state_d = S_WR;
                    k_d     = '0;
                    win_d   = w_gnt_idx;
                    rr_d    = w_gnt_idx;
                    val_d   = req_val[16*w_gnt_idx +: 16];
                    row_d   = req_row[3*w_gnt_idx +: 3];
                    col_d   = req_col[4*w_gnt_idx +: 4];
                end
            end
            S_WR: begin
                w_we    = 1'b1;
                // Column sum is 4 bits wide so it wraps within the row.
                w_waddr = {row_q, col_q + {2'b00, k_q}};
                w_wdata = {1'b1, w_nib};
                if (clr) clr_pend_d = 1'b1;
                if (k_q == 2'd3) state_d = S_ACK;
                else             k_d     = k_q + 2'd1;
            end
            S_ACK: begin
                if (clr) clr_pend_d = 1'b1;
                state_d = S_IDLE;
            end
            S_CLR: begin
                w_we    = 1'b1;
                w_waddr = cnt_q;
                w_wdata = '0;
                if (cnt_q == 7'd127) state_d = S_IDLE;
                else                 cnt_d   = cnt_q + 7'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == S_ACK) ack[win_q] = 1'b1;
    end

    assign busy = (state_q != S_IDLE);

    // Combinational read: a same-cycle write lands after this read.
    assign w_rd_cell  = text_mem_q[{char_y[2:0], char_x[3:0]}];
    assign w_in_range = (char_y < 7'd8) && (char_x < 7'd16);
    assign pix_d      = !blank && w_in_range && w_rd_cell[4] && char_data[w_rd_cell[3:0]];
    assign pix        = pix_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            rr_q       <= IW'(NREQ - 1);
            win_q      <= '0;
            val_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            clr_pend_q <= 1'b0;
            pix_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            win_q      <= win_d;
            val_q      <= val_d;
            row_q      <= row_d;
            col_q      <= col_d;
            clr_pend_q <= clr_pend_d;
            pix_q      <= pix_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) text_mem_q[w_waddr] <= w_wdata;
    end

endmodule
`default_nettype wire

// File: doc/hex_text_sched.md
HEX_TEXT_SCHED -- requirements
Module: hex_text_sched

Interface
REQ-001 Parameter NREQ, 4: number of requesters; fixed at 4 for this release.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req  in  4  per-requester write request; level, held until ack.
REQ-005 req_val  in  64  16-bit value per requester; requester i uses bits [16i+15:16i].
REQ-006 req_row  in  12  3-bit text row per requester; requester i uses bits [3i+2:3i].
REQ-007 req_col  in  16  4-bit start column per requester; requester i uses bits [4i+3:4i].
REQ-008 ack  out  4  one-cycle completion pulse per requester.
REQ-009 clr  in  1  one-cycle pulse; erase the whole text buffer.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 blank  in  1  display blanking.
REQ-012 char_x  in  7  character column from the font engine.
REQ-013 char_y  in  7  character row from the font engine.
REQ-014 char_data  in  16  glyph pixel bit per hex digit 0..F from the font engine.
REQ-015 pix  out  1  overlay pixel, registered.

Function
REQ-016 Text buffer: 8 rows x 16 columns; each entry holds a 4-bit digit plus a valid bit (128 entries).
REQ-017 Buffer has one write port (scheduler) and one read port (display); a same-cycle same-address access reads the old data.
REQ-018 FSM states: IDLE, WR, ACK, CLR.
REQ-019 IDLE: clr has priority; clr -> CLR. Otherwise, any req bit -> latch the round-robin winner's val/row/col -> WR with k=0.
REQ-020 Round-robin arbitration: search starts at last-granted index + 1 mod 4; after reset, the last-granted pointer is 3, so requester 0 wins first.
REQ-021 WR: on cycle k (0..3), write nibble val[15-4k:12-4k] with valid=1 at (row, (col+k) mod 16).
- Column wraps within the same row; it never carries into the next row.
REQ-022 After k=3 -> ACK: ack[winner] is high for exactly one cycle, then IDLE.
- Grant to ack latency is 5 cycles.
REQ-023 CLR: write valid=0 to addresses 0..127, one per cycle (128 cycles), then IDLE; no ack is issued.
REQ-024 A clr pulse that arrives during WR or ACK is latched and served on the next IDLE, ahead of requests.
- A clr pulse during CLR is ignored.
REQ-025 req changes during WR/ACK are ignored; the latched val/row/col are used for the whole write.
REQ-026 A requester that keeps req high after ack is re-arbitrated in IDLE like any other requester.
REQ-027 Display read: cell address = (char_y[2:0], char_x[3:0]); the cell is out-of-range if char_y>=8 or char_x>=16.
REQ-028 Display pixel: pix(n+1) = !blank(n) & inrange(n) & valid(n) & char_data(n)[digit(n)].
- Latency is 1 cycle from char_x/char_y/char_data.
- The buffer read is combinational, or registered with aligned delay; either way, the end-to-end latency from char_x/char_y/char_data to pix is 1.
REQ-029 Display reads are never stalled by the scheduler; a write becomes visible on the pix update following its write cycle.

Reset
REQ-030 While reset is low:
- FSM = IDLE; ack = 0, busy = 0, pix = 0.
- Round-robin pointer = 3; pending-clr flag = 0.
REQ-031 Buffer contents are not reset.
- After reset, software issues clr before display.
- Verification pulses clr before the first display check.
REQ-032 Reset assertion mid-WR or mid-CLR aborts immediately; the partially written buffer is left as is, and no ack is issued.

Verification
REQ-033 Set req=0001, val0=0x1A2F, row0=2, col0=4 -> cells (2,4..7) = 1,A,2,F valid; ack[0] pulses 5 cycles after grant; busy high for 5 cycles.
REQ-034 Set req=1111 and hold -> ack order 0,1,2,3,0 with 6-cycle spacing; no requester is skipped.
REQ-035 Set col=14 with val=0x1234 -> cells (r,14)=1, (r,15)=2, (r,0)=3, (r,1)=4; row r+1 is untouched.
REQ-036 Pulse clr during WR of requester 1 -> write completes and ack[1] pulses; CLR then runs for 128 cycles before requester 2 is granted; afterwards all valid=0 and pix stays 0.
REQ-037 Buffer cell (0,0)=digit 8, char_x=0, char_y=0, char_data=0x0100, blank=0 -> pix=1 next cycle; blank=1 -> pix=0; char_x=16 -> pix=0.
REQ-038 Drop reset low during WR at k=2 -> outputs at reset values at once; cells k=0,1 are written and cells k=2,3 are unchanged; no ack.
